cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Miss-handling stage directly below the data cache inside the memory subsystem.
- On a cache miss, optionally writes back the dirty victim line, then fetches the missing line word-by-word from main memory.
- Streams each fetched word into the cache line storage and pulses completion so the cache can update tag/valid and replay the access.
- Memory side is a single-word req/ack handshake with arbitrary latency.

Parameters:
addr_width, 32, byte address width
data_width, 32, word width; fixed at 32 (byte offset = 2 bits)
line_words, 4, words per cache line; power of two, >= 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
miss_valid  in  1  cache reports miss; held high until fill_done
miss_addr  in  addr_width  faulting byte address; stable while miss_valid
victim_dirty  in  1  victim line dirty; sampled at miss acceptance
victim_addr  in  addr_width  victim line base address; stable while miss_valid
victim_word  in  data_width  victim word at wb_idx (combinational from cache)
wb_idx  out  $clog2(line_words)  victim word index being written back
fill_we  out  1  write fill_data into line word fill_idx this cycle
fill_idx  out  $clog2(line_words)  line word index for fill
fill_data  out  data_width  word to store
fill_done  out  1  one-cycle pulse: line complete
busy  out  1  FSM not in IDLE
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  addr_width  word-aligned memory address
mem_wdata  out  data_width  write data
mem_ack  in  1  memory accepts/completes current request this cycle
mem_rdata  in  data_width  read data, valid when mem_ack && !mem_we

Behaviour:
- Reset values: busy, mem_req, mem_we, fill_we and fill_done are 0; mem_addr, mem_wdata, wb_idx and fill_idx are 0; state is IDLE; counters are 0.
- Reset mid-operation: abandon the transaction immediately; no fill_done is produced.
- States: IDLE, WB, FILL, DONE.
- IDLE:
  - miss_valid=1 goes to WB if victim_dirty, else FILL.
  - Latch the line base as miss_addr with the low $clog2(line_words)+2 bits cleared.
  - Clear the word counter.
- WB:
  - mem_req=1, mem_we=1, mem_addr = victim_addr base + 4*cnt, mem_wdata = victim_word, wb_idx = cnt.
  - On mem_ack: cnt++. On the last word's ack: cnt=0, go to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = latched base + 4*idx.
  - On mem_ack: fill_we=1 in the same cycle, fill_idx = idx, fill_data = mem_rdata; cnt++.
  - On the last ack: go to DONE.
- DONE:
  - fill_done=1 for exactly one cycle, then IDLE.
  - A new miss is accepted no earlier than the cycle after DONE.
- Handshake:
  - mem_req, mem_addr, mem_we and mem_wdata are stable while waiting for ack.
  - mem_ack with mem_req=0 is ignored.
  - Back-to-back: after an ack, the next word's req is presented the following cycle (mem_req may stay high).
  - Zero-wait memory (mem_ack tied high) completes one word per cycle.
- Latency, clean miss with 1-cycle ack: line_words FILL cycles + 1 DONE cycle.
- Latency, dirty miss: 2*line_words + 1 cycles.
- miss_valid dropping while busy is a protocol violation.
  - Simulation-only assertion.
  - The FSM still completes.
- Counter wraps are not used; the terminal compare is cnt == line_words-1.

Optional Feature:
CRIT_WORD_FIRST_EN
- Defined: FILL starts at word index miss_addr[$clog2(line_words)+1:2] and wraps modulo line_words.
  - fill_idx follows the wrapped index.
  - Completion is still after line_words acks.
- Undefined: FILL always starts at index 0.
- WB order is always 0..line_words-1.

Decomposition:
- Shared package mem_pkg:
  - refill_state_e enum (IDLE/WB/FILL/DONE).
  - WORD_BYTES=4 constant.
  - Line-offset helper function line_base(addr).
- Sub-module: none needed. Counter and FSM live in one module; the address generator is inline.

Test Plan:
- Clean miss, miss_addr=0x0000_1234, line_words=4, ack every cycle:
  - reads at 0x1230, 0x1234, 0x1238, 0x123C.
  - fill_idx 0..3 carry mem_rdata.
  - fill_done pulses on cycle 5.
- Dirty miss, victim_addr=0x0000_8000, miss_addr=0x40:
  - 4 writes at 0x8000..0x800C with victim_word per wb_idx.
  - Then 4 reads at 0x40..0x4C.
  - fill_done once.
- Memory stalls, ack after 3 wait cycles per word:
  - mem_addr and mem_wdata hold steady during waits.
  - fill_we asserts only on ack cycles.
  - Total 16 cycles + DONE.
- Reset asserted during FILL after 2 acks:
  - next cycle all outputs return to reset values and no fill_done.
  - A following miss restarts at word 0.
- CRIT_WORD_FIRST_EN defined, miss_addr=0x1238:
  - read order 0x1238, 0x123C, 0x1230, 0x1234.
  - fill_idx order 2, 3, 0, 1.
- Spurious mem_ack in IDLE: no state change, no fill_we.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the cache refill controller
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    localparam int unsigned WORD_BYTES = 4;

    // Clears the line-offset bits; callers cast the result back to their own address width.
    function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned words);
        logic [63:0] span;
        span = 64'(words) * 64'(WORD_BYTES);
        return addr & ~(span - 64'd1);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - dirty-victim write-back and line refill FSM (optional CRIT_WORD_FIRST_EN)
module cache_refill_ctrl
    import mem_pkg::*;
#(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int line_words = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          miss_valid,
    input  logic [addr_width-1:0]         miss_addr,
    input  logic                          victim_dirty,
    input  logic [addr_width-1:0]         victim_addr,
    input  logic [data_width-1:0]         victim_word,
    output logic [$clog2(line_words)-1:0] wb_idx,
    output logic                          fill_we,
    output logic [$clog2(line_words)-1:0] fill_idx,
    output logic [data_width-1:0]         fill_data,
    output logic                          fill_done,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [addr_width-1:0]         mem_addr,
    output logic [data_width-1:0]         mem_wdata,
    input  logic                          mem_ack,
    input  logic [data_width-1:0]         mem_rdata
);

    localparam int IW = $clog2(line_words);
    localparam logic [IW-1:0] LAST = IW'(line_words - 1);

    refill_state_e         state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic [addr_width-1:0] base_q, base_d;
    logic [IW-1:0]         fidx;
    logic [addr_width-1:0] miss_base;
    logic [addr_width-1:0] victim_base;

    assign miss_base   = addr_width'(line_base(64'(miss_addr), line_words));
    assign victim_base = addr_width'(line_base(64'(victim_addr), line_words));

`ifdef CRIT_WORD_FIRST_EN
    logic [IW-1:0] start_q, start_d;

    // Power-of-two line size makes the natural counter overflow the modulo wrap.
    assign fidx = start_q + cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
        end else begin
            start_q <= start_d;
        end
    end

    always_comb begin
        start_d = start_q;
        if (state_q == IDLE && miss_valid) begin
            start_d = miss_addr[IW+1:2];
        end
    end
`else
    assign fidx = cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wb_idx    = '0;
        fill_we   = 1'b0;
        fill_idx  = '0;
        fill_data = '0;
        fill_done = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    state_d = victim_dirty ? WB : FILL;
                    base_d  = miss_base;
                    cnt_d   = '0;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = victim_base + addr_width'({cnt_q, 2'b00});
                mem_wdata = victim_word;
                wb_idx    = cnt_q;
                if (mem_ack) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = base_q + addr_width'({fidx, 2'b00});
                fill_idx = fidx;
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    fill_data = mem_rdata;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                fill_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The cache must hold its miss request until the line has been delivered.
    a_miss_held: assert property (@(posedge clk) disable iff (rst) (state_q != IDLE) |-> miss_valid);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = 2;
    localparam logic [31:0] VW_BASE = 32'hBEEF_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic          victim_dirty;
    logic [AW-1:0] victim_addr;
    logic [DW-1:0] victim_word;
    logic [IW-1:0] wb_idx;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          fill_done;
    logic          busy;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    cache_refill_ctrl #(.addr_width(AW), .data_width(DW), .line_words(LW)) dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
        .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_word(victim_word),
        .wb_idx(wb_idx), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .fill_done(fill_done), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Cache storage stand-in: victim word content is a function of the word index.
    assign victim_word = VW_BASE | 32'(wb_idx);

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct packed { logic [IW-1:0] idx; logic [31:0] data; } fill_t;

    req_t        exp_req[$];
    fill_t       exp_fill[$];
    logic [31:0] rd_log[$];
    int          fidx_log[$];
    int          done_seen = 0;
    bit          chk_en = 1'b0;
    int          wait_cfg = 0;
    bit          spurious = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_miss(input logic [31:0] maddr, input bit dirty, input logic [31:0] vaddr);
        logic [31:0] mb, vb, a;
        int start, idx;
        mb = maddr & ~32'(LW * 4 - 1);
        vb = vaddr & ~32'(LW * 4 - 1);
        if (dirty) begin
            for (int i = 0; i < LW; i++) begin
                exp_req.push_back('{we: 1'b1, addr: vb + 32'(4 * i), wdata: VW_BASE | 32'(i)});
            end
        end
        start = 0;
`ifdef CRIT_WORD_FIRST_EN
        start = int'((maddr >> 2) % LW);
`endif
        for (int k = 0; k < LW; k++) begin
            idx = (start + k) % LW;
            a   = mb + 32'(4 * idx);
            exp_req.push_back('{we: 1'b0, addr: a, wdata: 32'h0});
            exp_fill.push_back('{idx: IW'(idx), data: mem_val(a)});
        end
    endtask

    // Memory responder: ack after wait_cfg wait cycles, or unconditionally when spurious.
    int waitc = 0;
    always @(posedge clk) begin
        #2;
        if (spurious) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (mem_req) begin
            if (waitc >= wait_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_we ? 32'h0 : mem_val(mem_addr);
                waitc     = 0;
            end else begin
                mem_ack = 1'b0;
                waitc++;
            end
        end else begin
            mem_ack = 1'b0;
            waitc   = 0;
        end
    end

    logic        prev_pend = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    req_t        er;
    fill_t       ef;

    always @(negedge clk) begin
        if (fill_done) done_seen++;
        if (chk_en && !rst) begin
            if (prev_pend) begin
                check("hold_req", mem_req, 1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_we", mem_we, prev_we);
                check("hold_wdata", mem_wdata, prev_wdata);
            end
            if (mem_req && mem_ack) begin
                if (exp_req.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h, required no request", mem_addr);
                end else begin
                    er = exp_req.pop_front();
                    check("req_we", mem_we, er.we);
                    check("req_addr", mem_addr, er.addr);
                    if (er.we) check("req_wdata", mem_wdata, er.wdata);
                end
                if (!mem_we) rd_log.push_back(mem_addr);
            end
            if (fill_we) begin
                check("fill_on_ack", mem_req && mem_ack && !mem_we, 1);
                if (exp_fill.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_fill: got idx %0d, required no fill", fill_idx);
                end else begin
                    ef = exp_fill.pop_front();
                    check("fill_idx", fill_idx, ef.idx);
                    check("fill_data", fill_data, ef.data);
                end
                fidx_log.push_back(int'(fill_idx));
            end else if (mem_req && mem_ack && !mem_we) begin
                check("fill_we_on_read_ack", fill_we, 1);
            end
        end
        prev_pend  = mem_req && !mem_ack && !rst;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic start_miss(input logic [31:0] maddr, input bit dirty, input logic [31:0] vaddr);
        expect_miss(maddr, dirty, vaddr);
        rd_log.delete();
        fidx_log.delete();
        @(posedge clk);
        #1;
        miss_addr    = maddr;
        victim_dirty = dirty;
        victim_addr  = vaddr;
        miss_valid   = 1'b1;
    endtask

    task automatic run_miss(input string name, input logic [31:0] maddr, input bit dirty,
                            input logic [31:0] vaddr, input int exp_lat);
        int d0, lat;
        bit got;
        d0  = done_seen;
        got = 1'b0;
        lat = 0;
        start_miss(maddr, dirty, vaddr);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (fill_done) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no fill_done, required one within 300 cycles", name);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
        end
        @(posedge clk);
        #1;
        miss_valid   = 1'b0;
        victim_dirty = 1'b0;
        @(negedge clk);
        check({name, "_done_once"}, done_seen - d0, 1);
        check({name, "_model_drained"}, exp_req.size() + exp_fill.size(), 0);
        check({name, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int d0;
        rst          = 1'b1;
        miss_valid   = 1'b0;
        miss_addr    = '0;
        victim_dirty = 1'b0;
        victim_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_fill_done", fill_done, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_idx", wb_idx, 0);
        check("rst_fill_idx", fill_idx, 0);
        chk_en = 1'b1;

        // Clean miss, zero-wait memory.
        run_miss("clean", 32'h0000_1234, 1'b0, 32'h0, 5);
        check("clean_nreads", rd_log.size(), 4);
`ifdef CRIT_WORD_FIRST_EN
        if (rd_log.size() == 4) begin
            check("clean_rd0", rd_log[0], 32'h1234);
            check("clean_rd3", rd_log[3], 32'h1230);
        end
`else
        if (rd_log.size() == 4) begin
            check("clean_rd0", rd_log[0], 32'h1230);
            check("clean_rd1", rd_log[1], 32'h1234);
            check("clean_rd2", rd_log[2], 32'h1238);
            check("clean_rd3", rd_log[3], 32'h123C);
        end
`endif

        // Dirty miss: write-back then refill.
        run_miss("dirty", 32'h0000_0040, 1'b1, 32'h0000_8000, 9);
        if (rd_log.size() == 4) check("dirty_rd0", rd_log[0], 32'h40);

        // Stalling memory: three wait cycles per word.
        wait_cfg = 3;
        run_miss("stall", 32'h0000_3010, 1'b0, 32'h0, 17);
        wait_cfg = 1;
        run_miss("dirty_stall", 32'h0000_5678, 1'b1, 32'h0000_9AB0, 17);
        wait_cfg = 0;

        // Critical-word order test address.
        run_miss("crit", 32'h0000_1238, 1'b0, 32'h0, 5);
        if (rd_log.size() == 4 && fidx_log.size() == 4) begin
`ifdef CRIT_WORD_FIRST_EN
            check("crit_rd0", rd_log[0], 32'h1238);
            check("crit_rd2", rd_log[2], 32'h1230);
            check("crit_idx0", fidx_log[0], 2);
            check("crit_idx2", fidx_log[2], 0);
`else
            check("crit_rd0", rd_log[0], 32'h1230);
            check("crit_idx0", fidx_log[0], 0);
            check("crit_idx3", fidx_log[3], 3);
`endif
        end

        // Reset in the middle of FILL, after two read acks.
        start_miss(32'h0000_2000, 1'b0, 32'h0);
        for (int c = 0; c < 100 && fidx_log.size() < 2; c++) @(negedge clk);
        check("rstmid_two_acks", fidx_log.size(), 2);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        miss_valid = 1'b0;
        chk_en     = 1'b0;
        exp_req.delete();
        exp_fill.delete();
        d0 = done_seen;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_busy", busy, 0);
        check("rstmid_mem_req", mem_req, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_fill_we", fill_we, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_no_done", done_seen - d0, 0);
        run_miss("restart", 32'h0000_2000, 1'b0, 32'h0, 5);
        if (rd_log.size() > 0) check("restart_rd0", rd_log[0], 32'h2000);

        // Spurious ack while idle.
        @(posedge clk);
        #1;
        spurious = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("spur_busy", busy, 0);
            check("spur_mem_req", mem_req, 0);
            check("spur_fill_we", fill_we, 0);
        end
        @(posedge clk);
        #1;
        spurious = 1'b0;
        run_miss("post_spur", 32'h0000_0100, 1'b0, 32'h0, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
